// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD step decoder.
package bcd_pkg;

   typedef enum logic [1:0] {INIT, HOLD, UP, DOWN} state_t;

   localparam logic [3:0] BCD_MAX = 4'd9;

   typedef logic [3:0] bcd_t;

   function automatic logic is_bcd(input logic [3:0] i_val);
      return i_val <= BCD_MAX;
   endfunction

endpackage

// File: rtl/bcd_tens_digit.sv
// Modulo-10 tens digit advanced by carry (inc) and borrow (dec) pulses.
module bcd_tens_digit
   import bcd_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic dec,
   output bcd_t digit
);

   bcd_t r_digit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_digit <= '0;
      end else if (inc) begin
         r_digit <= (r_digit == BCD_MAX) ? 4'd0 : r_digit + 4'd1;
      end else if (dec) begin
         r_digit <= (r_digit == 4'd0) ? BCD_MAX : r_digit - 4'd1;
      end
   end

   assign digit = r_digit;

endmodule

// File: rtl/bcd_step_decoder.sv
// Decodes direction, run/stall, carry/borrow and errors from a sampled BCD decade counter.
// Optional err pulse counter enabled by defining BCD_STEP_DECODER_ERR_CNT_EN.
module bcd_step_decoder
   import bcd_pkg::*;
#(
   parameter int unsigned STALL_CYC = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] cnt_in,
   output logic       dir,
   output logic       run,
   output logic       carry,
   output logic       borrow,
   output logic       err,
   output logic [3:0] tens,
   output logic [7:0] err_cnt
);

   localparam logic [3:0] STALL_LIM = 4'(STALL_CYC - 1);

   state_t     r_state;
   bcd_t       r_prev;
   logic [3:0] r_stall;
   logic       r_dir;
   logic       r_run;
   logic       r_carry;
   logic       r_borrow;
   logic       r_err;

   logic       w_legal;
   logic       w_decode;
   logic       w_up;
   logic       w_dn;
   logic       w_carry;
   logic       w_borrow;
   logic       w_err;
   logic [3:0] w_stall_nxt;

   // r_prev is always a legal digit whenever w_decode is set, so prev+1 never wraps past 9.
   always_comb begin
      w_legal     = is_bcd(cnt_in);
      w_decode    = (r_state != INIT);
      w_up        = (r_prev == BCD_MAX) ? (cnt_in == 4'd0) : (cnt_in == r_prev + 4'd1);
      w_dn        = (r_prev == 4'd0) ? (cnt_in == BCD_MAX) : (cnt_in == r_prev - 4'd1);
      w_carry     = w_decode && w_legal && w_up && (r_prev == BCD_MAX);
      w_borrow    = w_decode && w_legal && w_dn && (r_prev == 4'd0);
      w_err       = !w_legal || (w_decode && (cnt_in != r_prev) && !w_up && !w_dn);
      w_stall_nxt = (r_stall == 4'hF) ? 4'hF : r_stall + 4'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= INIT;
         r_prev   <= '0;
         r_stall  <= '0;
         r_dir    <= 1'b0;
         r_run    <= 1'b0;
         r_carry  <= 1'b0;
         r_borrow <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_prev   <= cnt_in;
         r_carry  <= w_carry;
         r_borrow <= w_borrow;
         r_err    <= w_err;
         if (w_err) begin
            r_state <= INIT;
            r_run   <= 1'b0;
            r_stall <= '0;
         end else begin
            case (r_state)
               INIT: begin
                  r_state <= HOLD;
                  r_run   <= 1'b0;
                  r_stall <= '0;
               end
               default: begin
                  if (w_up) begin
                     r_state <= UP;
                     r_dir   <= 1'b0;
                     r_run   <= 1'b1;
                     r_stall <= '0;
                  end else if (w_dn) begin
                     r_state <= DOWN;
                     r_dir   <= 1'b1;
                     r_run   <= 1'b1;
                     r_stall <= '0;
                  end else begin
                     // Repeated sample: counter may have stopped.
                     r_stall <= w_stall_nxt;
                     if (w_stall_nxt >= STALL_LIM) begin
                        r_state <= HOLD;
                        r_run   <= 1'b0;
                     end
                  end
               end
            endcase
         end
      end
   end

   bcd_tens_digit u_tens (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_carry),
      .dec   (w_borrow),
      .digit (tens)
   );

`ifdef BCD_STEP_DECODER_ERR_CNT_EN
   logic [7:0] r_err_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err_cnt <= '0;
      end else if (w_err && (r_err_cnt != 8'hFF)) begin
         r_err_cnt <= r_err_cnt + 8'd1;
      end
   end

   assign err_cnt = r_err_cnt;
`else
   assign err_cnt = '0;
`endif

   assign dir    = r_dir;
   assign run    = r_run;
   assign carry  = r_carry;
   assign borrow = r_borrow;
   assign err    = r_err;

endmodule

// File: tb/tb_bcd_step_decoder.sv
// Directed scoreboard bench for bcd_step_decoder (default STALL_CYC = 2).
module tb_bcd_step_decoder;

   typedef struct {
      logic       dir;
      logic       run;
      logic       carry;
      logic       borrow;
      logic       err;
      logic [3:0] tens;
      logic [7:0] ecnt;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] cnt_in;
   logic       dir;
   logic       run;
   logic       carry;
   logic       borrow;
   logic       err;
   logic [3:0] tens;
   logic [7:0] err_cnt;

   int   total = 0;
   int   bad   = 0;
   int   e_errs = 0;
   int   step_n = 0;
   exp_t sb[$];

   bcd_step_decoder dut (
      .clk     (clk),
      .rst     (rst),
      .cnt_in  (cnt_in),
      .dir     (dir),
      .run     (run),
      .carry   (carry),
      .borrow  (borrow),
      .err     (err),
      .tens    (tens),
      .err_cnt (err_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] exp_ecnt();
`ifdef BCD_STEP_DECODER_ERR_CNT_EN
      return (e_errs > 255) ? 8'hFF : 8'(e_errs);
`else
      return 8'h00;
`endif
   endfunction

   task automatic chk_zero(input string tag);
      chk({tag, ".dir"},    8'(dir),    8'h00);
      chk({tag, ".run"},    8'(run),    8'h00);
      chk({tag, ".carry"},  8'(carry),  8'h00);
      chk({tag, ".borrow"}, 8'(borrow), 8'h00);
      chk({tag, ".err"},    8'(err),    8'h00);
      chk({tag, ".tens"},   8'(tens),   8'h00);
      chk({tag, ".errcnt"}, err_cnt,    8'h00);
   endtask

   // Drive one sample just after an edge; expected outputs are checked after the next edge.
   task automatic s(input logic [3:0] v, input logic d, input logic r, input logic c,
                    input logic b, input logic e, input logic [3:0] t);
      exp_t x;
      string tag;
      cnt_in = v;
      if (e) e_errs++;
      x = '{dir: d, run: r, carry: c, borrow: b, err: e, tens: t, ecnt: exp_ecnt()};
      sb.push_back(x);
      @(posedge clk);
      #1;
      step_n++;
      x = sb.pop_front();
      tag = $sformatf("s%0d(in=%0d)", step_n, v);
      chk({tag, ".dir"},    8'(dir),    8'(x.dir));
      chk({tag, ".run"},    8'(run),    8'(x.run));
      chk({tag, ".carry"},  8'(carry),  8'(x.carry));
      chk({tag, ".borrow"}, 8'(borrow), 8'(x.borrow));
      chk({tag, ".err"},    8'(err),    8'(x.err));
      chk({tag, ".tens"},   8'(tens),   8'(x.tens));
      chk({tag, ".errcnt"}, err_cnt,    x.ecnt);
   endtask

   initial begin
      rst    = 1'b1;
      cnt_in = 4'd0;
      @(posedge clk);
      #1;
      chk_zero("reset");
      rst = 1'b0;

      // Load, then start counting up.
      s(4'd3, 0, 0, 0, 0, 0, 4'd0);
      s(4'd4, 0, 1, 0, 0, 0, 4'd0);
      for (int v = 5; v <= 9; v++) s(4'(v), 0, 1, 0, 0, 0, 4'd0);
      s(4'd0, 0, 1, 1, 0, 0, 4'd1);
      s(4'd1, 0, 1, 0, 0, 0, 4'd1);

      // Reverse and count down through two borrows.
      s(4'd0, 1, 1, 0, 0, 0, 4'd1);
      s(4'd9, 1, 1, 0, 1, 0, 4'd0);
      for (int v = 8; v >= 0; v--) s(4'(v), 1, 1, 0, 0, 0, 4'd0);
      s(4'd9, 1, 1, 0, 1, 0, 4'd9);
      for (int v = 8; v >= 4; v--) s(4'(v), 1, 1, 0, 0, 0, 4'd9);

      // Illegal jump, then out-of-range sample; tens must hold.
      s(4'd7,  1, 0, 0, 0, 1, 4'd9);
      s(4'd12, 1, 0, 0, 0, 1, 4'd9);
      s(4'd3,  1, 0, 0, 0, 0, 4'd9);
      for (int v = 4; v <= 9; v++) s(4'(v), 0, 1, 0, 0, 0, 4'd9);
      s(4'd0, 0, 1, 1, 0, 0, 4'd0);

      // Immediate reversals across the 9/0 boundary.
      s(4'd9, 1, 1, 0, 1, 0, 4'd9);
      s(4'd0, 0, 1, 1, 0, 0, 4'd0);
      for (int v = 1; v <= 6; v++) s(4'(v), 0, 1, 0, 0, 0, 4'd0);

      // Stall: run drops after the second identical sample.
      s(4'd6, 0, 0, 0, 0, 0, 4'd0);
      s(4'd6, 0, 0, 0, 0, 0, 4'd0);
      for (int v = 7; v <= 9; v++) s(4'(v), 0, 1, 0, 0, 0, 4'd0);

      // Reset between edges while a 9->0 step is pending.
      cnt_in = 4'd0;
      #3;
      rst    = 1'b1;
      e_errs = 0;
      #1;
      chk_zero("rst_async");
      @(posedge clk);
      #1;
      chk_zero("rst_held");
      rst = 1'b0;
      s(4'd0, 0, 0, 0, 0, 0, 4'd0);
      s(4'd1, 0, 1, 0, 0, 0, 4'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bcd_step_decoder.md
BCD_STEP_DECODER -- requirements
Module: bcd_step_decoder

Interface
REQ-001 SHALL have parameter STALL_CYC, default 2: number of consecutive identical samples that marks the counter as stopped (legal range 1..15).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port cnt_in, input, 4 bits: BCD digit sampled from the up/down decade counter.
REQ-005 SHALL have port dir, output, 1 bit: last decoded direction; 0 = up, 1 = down (same sense as the counter's u input).
REQ-006 SHALL have port run, output, 1 bit: 1 while the counter is stepping.
REQ-007 SHALL have port carry, output, 1 bit: one-cycle pulse on a 9->0 step.
REQ-008 SHALL have port borrow, output, 1 bit: one-cycle pulse on a 0->9 step.
REQ-009 SHALL have port err, output, 1 bit: one-cycle pulse on an illegal sample or illegal step.
REQ-010 SHALL have port tens, output, 4 bits: reconstructed BCD tens digit.
REQ-011 SHALL have port err_cnt, output, 8 bits: saturating count of err pulses.

Function
REQ-012 SHALL register cnt_in every cycle into prev; every output SHALL be registered, so each output reflects the step between prev and cnt_in one cycle after cnt_in changes.
REQ-013 SHALL implement the states INIT, HOLD, UP and DOWN.
REQ-014 INIT: the first legal sample (0..9) SHALL load prev and move to HOLD with run=0; no step is decoded in this state.
REQ-015 A legal up step is cnt_in == prev+1, or prev=9 with cnt_in=0; it SHALL set dir=0, run=1 and the state to UP.
REQ-016 A legal down step is cnt_in == prev-1, or prev=0 with cnt_in=9; it SHALL set dir=1, run=1 and the state to DOWN.
REQ-017 An equal sample SHALL increment a 4-bit saturating stall counter; when the counter reaches STALL_CYC-1, the block SHALL go to HOLD with run=0 and dir kept. Any legal step SHALL clear the stall counter.
REQ-018 On a 9->0 step, carry SHALL pulse and tens SHALL increment modulo 10 (9->0).
REQ-019 On a 0->9 step, borrow SHALL pulse and tens SHALL decrement modulo 10 (0->9).
REQ-020 carry and borrow SHALL never be asserted in the same cycle.
REQ-021 On cnt_in > 9 or any other step, err SHALL pulse, run SHALL clear, tens SHALL be kept, and the state SHALL go to INIT.
REQ-022 A reversal (UP to a legal down step, or DOWN to a legal up step) is legal, SHALL NOT raise err, and takes effect immediately.

Reset
REQ-023 Asserting rst SHALL force state=INIT, prev=0, stall counter=0, dir=0, run=0, carry=0, borrow=0, err=0, tens=0 and err_cnt=0, independent of clk.
REQ-024 rst asserted mid-step SHALL discard any pending pulse; the first edge after release SHALL behave as in INIT.

Configuration
REQ-025 With macro BCD_STEP_DECODER_ERR_CNT_EN defined, err_cnt SHALL increment on each err pulse and saturate at 255.
REQ-026 Without the macro, err_cnt SHALL be a constant 0, no counter logic SHALL be built, and the port SHALL still exist.

Structure
REQ-027 Package bcd_pkg SHALL hold the state enum (INIT, HOLD, UP, DOWN), BCD_MAX=9, and the 4-bit BCD digit typedef.
REQ-028 The tens digit SHALL be a sub-module, bcd_tens_digit, that takes inc and dec and produces a 4-bit modulo-10 value with asynchronous reset.

Verification
REQ-029 Reset release, then cnt_in 3,4,5 on successive cycles -> HOLD after 3; run=1, dir=0 after 4; no err.
REQ-030 cnt_in 8,9,0,1 -> one carry pulse one cycle after 0 appears; tens 0->1; borrow stays 0.
REQ-031 cnt_in 1,0,9,8 starting from tens=0 -> one borrow pulse; tens=9; dir=1.
REQ-032 Counting up, then cnt_in held at 6 for 3 cycles with STALL_CYC=2 -> run falls 1 cycle after the second 6; dir stays 0; no err.
REQ-033 cnt_in 4 then 7, followed by cnt_in 12 -> err pulses each time; state=INIT; tens unchanged; err_cnt=2 with the macro, 0 without.
REQ-034 rst asserted between clk edges during a 9->0 step -> all outputs 0 immediately; no carry pulse after release.
